// File: rtl/load_data_unit_pkg.sv
// Shared encodings for the load/store data lane logic: select codes, FSM states, error codes.
package load_data_unit_pkg;

   localparam logic [2:0] SEL_LW  = 3'b000;
   localparam logic [2:0] SEL_LH  = 3'b001;
   localparam logic [2:0] SEL_LB  = 3'b010;
   localparam logic [2:0] SEL_LHU = 3'b101;
   localparam logic [2:0] SEL_LBU = 3'b110;

   localparam logic [1:0] ST_SEL_SB = 2'b00;
   localparam logic [1:0] ST_SEL_SH = 2'b01;
   localparam logic [1:0] ST_SEL_SW = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_DONE  = 2'b11
   } ldu_state_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_ILLEGAL  = 2'b11
   } ldu_err_e;

   function automatic logic sel_legal(input logic [2:0] sel);
      return (sel == SEL_LW) || (sel == SEL_LH) || (sel == SEL_LB) ||
             (sel == SEL_LHU) || (sel == SEL_LBU);
   endfunction

   function automatic logic sel_misaligned(input logic [2:0] sel, input logic [1:0] off);
      return ((sel == SEL_LW) && (off != 2'b00)) ||
             (((sel == SEL_LH) || (sel == SEL_LHU)) && off[0]);
   endfunction

endpackage

// File: rtl/load_data_unit_if.sv
// Request, memory-read and writeback signals of the load data unit.
interface load_data_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_load_sel;
   logic [4:0]  req_rd;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_err;

   modport slave (
      input  req_valid, req_addr, req_load_sel, req_rd, mem_rvalid, mem_rdata, wb_ready,
      output req_ready, mem_rd_en, mem_addr, wb_valid, wb_data, wb_rd, wb_err
   );

   modport master (
      output req_valid, req_addr, req_load_sel, req_rd, mem_rvalid, mem_rdata, wb_ready,
      input  req_ready, mem_rd_en, mem_addr, wb_valid, wb_data, wb_rd, wb_err
   );
endinterface

// File: rtl/load_data_unit_extend.sv
// Lane select and zero/sign extension of a little-endian read word.
module load_extend
   import load_data_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  sel_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata_i[7:0];
      case (off_i)
         2'b00: byte_lane = rdata_i[7:0];
         2'b01: byte_lane = rdata_i[15:8];
         2'b10: byte_lane = rdata_i[23:16];
         2'b11: byte_lane = rdata_i[31:24];
         default: byte_lane = rdata_i[7:0];
      endcase
      half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      result_o = '0;
      case (sel_i)
         SEL_LW:  result_o = rdata_i;
         SEL_LH:  result_o = {{16{half_lane[15]}}, half_lane};
         SEL_LB:  result_o = {{24{byte_lane[7]}}, byte_lane};
         SEL_LHU: result_o = {16'h0000, half_lane};
         SEL_LBU: result_o = {24'h000000, byte_lane};
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/load_data_unit.sv
// Load data unit: issues a word read, waits for the response with a timeout,
// extracts/extends the addressed lane and hands the result to writeback.
//  state | meaning
//  IDLE  | ready for a request; error requests go straight to DONE
//  ISSUE | one-cycle mem_rd_en strobe, wait counter cleared
//  WAIT  | waiting for mem_rvalid or timeout
//  DONE  | result held on wb_* until wb_ready
module load_data_unit
   import load_data_unit_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   load_data_unit_if.slave  bus
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT - 1);

   ldu_state_e       state_q;
   logic [2:0]       sel_q;
   logic [1:0]       off_q;
   logic [29:0]      addr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      wb_data_q;
   logic [4:0]       wb_rd_q;
   ldu_err_e         wb_err_q;
   logic [31:0]      ext_data;

   load_extend u_extend (
      .rdata_i  (bus.mem_rdata),
      .off_i    (off_q),
      .sel_i    (sel_q),
      .result_o (ext_data)
   );

   assign cnt_d = cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         sel_q     <= SEL_LW;
         off_q     <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         wb_data_q <= '0;
         wb_rd_q   <= '0;
         wb_err_q  <= ERR_OK;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  sel_q     <= bus.req_load_sel;
                  off_q     <= bus.req_addr[1:0];
                  addr_q    <= bus.req_addr[31:2];
                  wb_rd_q   <= bus.req_rd;
                  wb_data_q <= '0;
                  // illegal select takes priority over alignment
                  if (!sel_legal(bus.req_load_sel)) begin
                     wb_err_q <= ERR_ILLEGAL;
                     state_q  <= ST_DONE;
                  end else if (sel_misaligned(bus.req_load_sel, bus.req_addr[1:0])) begin
                     wb_err_q <= ERR_MISALIGN;
                     state_q  <= ST_DONE;
                  end else begin
                     wb_err_q <= ERR_OK;
                     state_q  <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               cnt_q   <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // a response on the last allowed cycle still counts as success
               if (bus.mem_rvalid) begin
                  wb_data_q <= ext_data;
                  wb_err_q  <= ERR_OK;
                  state_q   <= ST_DONE;
               end else if (cnt_q == TIMEOUT_CNT) begin
                  wb_data_q <= '0;
                  wb_err_q  <= ERR_TIMEOUT;
                  state_q   <= ST_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DONE: begin
               if (bus.wb_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.mem_rd_en = (state_q == ST_ISSUE);
   assign bus.wb_valid  = (state_q == ST_DONE);
   assign bus.mem_addr  = {addr_q, 2'b00};
   assign bus.wb_data   = wb_data_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_load_data_unit.sv
// Directed and randomized checks of load_data_unit against an arithmetic reference model.
module tb_load_data_unit;

   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   load_data_unit_if bus ();

   load_data_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference: pick lane by shifting the word, then extend with arithmetic
   function automatic logic [31:0] ref_data(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [2:0] sel);
      logic [31:0] w;
      case (sel)
         3'b000: return rdata;
         3'b001, 3'b101: begin
            w = (rdata >> ((off >= 2'd2) ? 16 : 0)) & 32'h0000FFFF;
            if (sel == 3'b001 && w >= 32'h8000) w = w + 32'hFFFF0000;
            return w;
         end
         3'b010, 3'b110: begin
            w = (rdata >> (8 * int'(off))) & 32'h000000FF;
            if (sel == 3'b010 && w >= 32'h80) w = w + 32'hFFFFFF00;
            return w;
         end
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [1:0] ref_err(input logic [31:0] addr, input logic [2:0] sel);
      if (!(sel inside {3'b000, 3'b001, 3'b010, 3'b101, 3'b110})) return 2'b11;
      if (sel == 3'b000 && addr[1:0] != 2'b00) return 2'b01;
      if ((sel == 3'b001 || sel == 3'b101) && addr[0]) return 2'b01;
      return 2'b00;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
      check({tag, "_rd_en"},     {31'b0, bus.mem_rd_en}, 32'd0);
      check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
      check({tag, "_wb_valid"},  {31'b0, bus.wb_valid}, 32'd0);
      check({tag, "_wb_data"},   bus.wb_data, 32'd0);
      check({tag, "_wb_rd"},     {27'b0, bus.wb_rd}, 32'd0);
      check({tag, "_wb_err"},    {30'b0, bus.wb_err}, 32'd0);
   endtask

   task automatic accept(input logic [31:0] addr, input logic [2:0] sel, input logic [4:0] rd);
      int guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("req_ready_before_accept", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_addr     = addr;
      bus.req_load_sel = sel;
      bus.req_rd       = rd;
      @(posedge clk); #1;
      bus.req_valid    = 1'b0;
      bus.req_addr     = $urandom;
      bus.req_load_sel = 3'($urandom);
      bus.req_rd       = 5'($urandom);
   endtask

   // Called at #1 after the accepting edge. lat = WAIT cycle carrying mem_rvalid (0 = never).
   task automatic finish_load(input logic [31:0] addr, input logic [2:0] sel, input logic [4:0] rd,
                              input logic [31:0] rdata, input int lat, input int wbdelay,
                              input bit do_release);
      logic [1:0]  exp_err;
      logic [31:0] exp_data;
      int          k;
      int          exp_wait;
      exp_err  = ref_err(addr, sel);
      exp_data = 32'h0;
      if (exp_err != 2'b00) begin
         check("err_no_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
      end else begin
         check("issue_rd_en", {31'b0, bus.mem_rd_en}, 32'd1);
         check("issue_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
         @(posedge clk); #1;
         k = 0;
         while (bus.wb_valid !== 1'b1 && k < TIMEOUT + 4) begin
            k++;
            check("wait_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
            check("wait_mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
            if (k == lat) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = rdata;
            end else begin
               bus.mem_rvalid = 1'b0;
               bus.mem_rdata  = $urandom;
            end
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
         end
         if (lat >= 1 && lat <= TIMEOUT) begin
            exp_wait = lat;
            exp_data = ref_data(rdata, addr[1:0], sel);
         end else begin
            exp_wait = TIMEOUT;
            exp_err  = 2'b10;
         end
         check("wait_cycles", k, exp_wait);
      end
      check("wb_valid", {31'b0, bus.wb_valid}, 32'd1);
      check("wb_data", bus.wb_data, exp_data);
      check("wb_err", {30'b0, bus.wb_err}, {30'b0, exp_err});
      check("wb_rd", {27'b0, bus.wb_rd}, {27'b0, rd});
      for (int i = 0; i < wbdelay; i++) begin
         bus.mem_rvalid = 1'($urandom);
         bus.mem_rdata  = $urandom;
         @(posedge clk); #1;
         check("hold_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
         check("hold_wb_data", bus.wb_data, exp_data);
         check("hold_wb_rd", {27'b0, bus.wb_rd}, {27'b0, rd});
         check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      end
      bus.mem_rvalid = 1'b0;
      if (do_release) begin
         bus.wb_ready = 1'b1;
         @(posedge clk); #1;
         bus.wb_ready = 1'b0;
         check("release_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
         check("release_req_ready", {31'b0, bus.req_ready}, 32'd1);
      end
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [2:0] sel, input logic [4:0] rd,
                          input logic [31:0] rdata, input int lat, input int wbdelay);
      accept(addr, sel, rd);
      finish_load(addr, sel, rd, rdata, lat, wbdelay, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [2:0]  s;
      logic [2:0]  sels [8];
      sels = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b011, 3'b100, 3'b111};

      reset            = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_addr     = '0;
      bus.req_load_sel = '0;
      bus.req_rd       = '0;
      bus.mem_rvalid   = 1'b0;
      bus.mem_rdata    = '0;
      bus.wb_ready     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      reset = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEADBEEF;
      repeat (2) begin
         @(posedge clk); #1;
      end
      bus.mem_rvalid = 1'b0;
      check_reset_vals("stale_rvalid_idle");

      do_load(32'h0000_1003, 3'b010, 5'd3,  32'h80FF7F01, 1, 0);
      do_load(32'h0000_2002, 3'b101, 5'd4,  32'h8001ABCD, 2, 1);
      do_load(32'h0000_2002, 3'b001, 5'd5,  32'h8001ABCD, 1, 0);
      do_load(32'h0000_2001, 3'b110, 5'd6,  32'h8001ABCD, 4, 0);
      do_load(32'h0000_0006, 3'b000, 5'd7,  32'h12345678, 1, 0);
      do_load(32'h0000_0010, 3'b011, 5'd8,  32'h12345678, 1, 0);
      do_load(32'h0000_0020, 3'b000, 5'd9,  32'h12345678, 0, 0);
      do_load(32'h0000_0024, 3'b000, 5'd10, 32'hCAFEF00D, TIMEOUT, 0);
      do_load(32'h0000_0028, 3'b000, 5'd11, 32'h0BADC0DE, 3, 5);

      accept(32'h0000_3000, 3'b110, 5'd12);
      finish_load(32'h0000_3000, 3'b110, 5'd12, 32'h11223344, 2, 0, 1'b0);
      bus.wb_ready     = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_addr     = 32'h0000_3002;
      bus.req_load_sel = 3'b101;
      bus.req_rd       = 5'd13;
      @(posedge clk); #1;
      bus.wb_ready = 1'b0;
      check("b2b_idle_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
      check("b2b_idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("b2b_accepted", {31'b0, bus.req_ready}, 32'd0);
      finish_load(32'h0000_3002, 3'b101, 5'd13, 32'hFEDC0000, 3, 0, 1'b1);

      accept(32'h0000_0040, 3'b000, 5'd14);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_vals("reset_in_wait");
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h55AA55AA;
      repeat (3) begin
         @(posedge clk); #1;
         check("late_rvalid_no_wb", {31'b0, bus.wb_valid}, 32'd0);
      end
      bus.mem_rvalid = 1'b0;
      check_reset_vals("after_late_rvalid");
      do_load(32'h0000_0044, 3'b000, 5'd15, 32'h76543210, 2, 0);

      for (int it = 0; it < 30; it++) begin
         s = ($urandom_range(0, 9) < 8) ? sels[$urandom_range(0, 4)] : sels[$urandom_range(5, 7)];
         a = $urandom;
         if (s == 3'b000 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if ((s == 3'b001 || s == 3'b101) && $urandom_range(0, 3) != 0) a[0] = 1'b0;
         d = $urandom;
         do_load(a, s, 5'($urandom), d, $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
